y86_regfile_pipe: RTL and testbench
===================================

// Module: y86_regfile_pipe
// PURPOSE
// - Parametrised Y86-64 register file for the pipelined core; successor to the SEQ decode/writeback regfile.
// - Two combinational read ports (srcA/srcB) serve decode; two write ports (E, M) are driven by writeback.
// - Per-register pending-write scoreboard flags load-use and data hazards so decode can stall.
// - Sits between the decode and writeback stages.
// PARAMETERS
// - DATA_W   64  register width in bits
// - NUM_REGS 15  architectural registers; index 4 is %rsp
// - ADDR_W   4   register-id width; id {ADDR_W{1'b1}} (0xF) is RNONE
// - PEND_W   2   width of each pending-write counter (up to 3 outstanding)
// PORTS
// - clock      in   1         rising-edge clock
// - reset      in   1         asynchronous, active-high
// - srcA       in   ADDR_W    read port A register id
// - srcB       in   ADDR_W    read port B register id
// - valA       out  DATA_W    read data A
// - valB       out  DATA_W    read data B
// - wb_valid   in   1         writeback stage holds a valid instruction
// - dstE       in   ADDR_W    E-port destination (RNONE = no write; already cnd-qualified)
// - valE       in   DATA_W    E-port write data
// - dstM       in   ADDR_W    M-port destination (RNONE = no write)
// - valM       in   DATA_W    M-port write data
// - claim_en   in   1         decode issues an instruction; marks its destinations pending
// - claim_dstE in   ADDR_W    destination to mark via E
// - claim_dstM in   ADDR_W    destination to mark via M
// - stall      out  1         srcA or srcB has an outstanding write
// - sb_err     out  1         sticky: counter overflow or release with zero count
// - dbg_sel    in   ADDR_W    debug read select
// - dbg_data   out  DATA_W    debug read data (0 for RNONE or index >= NUM_REGS)
// BEHAVIOUR
// - Reset (async): all registers = 0, all pending counters = 0, sb_err = 0; valA/valB/dbg_data therefore read 0; stall = 0.
// - Reads are combinational, 0-cycle; a RNONE or out-of-range id reads 0 and never stalls.
// - Writes occur on the posedge when wb_valid = 1; RNONE or out-of-range dst is ignored.
// - dstE == dstM (e.g. popq %rsp): M-port data wins; the register is written once.
// - Scoreboard: claim_en increments pend[claim_dstE] and pend[claim_dstM].
//   - When both name the same register, it increments by 1 only.
// - Write release: a wb_valid write decrements pend[dst] (deduplicated the same way).
// - Claim and release of the same register in one cycle: count unchanged.
// - Overflow: a claim at count = 2^PEND_W-1 saturates and sets sb_err.
// - Underflow: a release at count 0 leaves it 0 and sets sb_err.
// - stall = (pend[srcA] != 0) | (pend[srcB] != 0), with the bypass exception below.
// - Reset mid-operation clears all pending state and data immediately; in-flight writes are lost.
// CONFIGURATION
// - Macro WB_BYPASS_EN.
//   - Defined: if srcA/srcB matches a dst being written this cycle (wb_valid = 1), the read returns the write data (M over E).
//   - Defined: stall is suppressed for that source when the matching count is exactly 1.
//   - Undefined: reads return stored state only; the new value is visible on the cycle after the edge, and stall holds until then.
// STRUCTURE
// - Shared package y86_pkg: REG_RSP = 4, RNONE = 4'hF, icode localparams, typedef reg_id_t.
// - One sub-module: y86_scoreboard, which owns the pending counters, sb_err and the stall computation.
// - Data storage and read/bypass muxing stay in the top module.
// TESTING
// - Reset then irmovq-style write: dstE = 3, valE = 0x1234, wb_valid = 1 -> next cycle srcA = 3 gives valA = 0x1234; dbg_sel = 3 matches.
// - Dual write to the same register: dstE = dstM = 4, valE = 0x100, valM = 0x200 -> r4 = 0x200; pend[4] decrements by 1.
// - Hazard: claim_dstE = 2, then srcB = 2 -> stall = 1 until the release edge.
//   - With WB_BYPASS_EN: stall = 0 and valB = valE in the release cycle.
// - RNONE everywhere: srcA = 0xF and dstM = 0xF writes -> valA = 0, no state change, stall = 0.
// - Overflow: 4 claims on r1 with no release -> sb_err = 1, held until reset.
// - Async reset asserted mid-stream while r5 is pending -> immediately stall = 0, valA(5) = 0, sb_err = 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register ids, instruction codes and id helpers.
package y86_pkg;

    typedef logic [3:0] reg_id_t;

    localparam reg_id_t REG_RSP = 4'h4;
    localparam reg_id_t RNONE   = 4'hF;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // RNONE and any id past the last architectural register name nothing.
    function automatic logic id_in_range(input int unsigned id, input int unsigned num_regs);
        return id < num_regs;
    endfunction

endpackage

// File: rtl/y86_regfile_pipe_if.sv
// Decode/writeback-facing bus of the pipelined register file.
interface y86_regfile_pipe_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic              wb_valid;
    logic [ADDR_W-1:0] dst_e;
    logic [DATA_W-1:0] val_e;
    logic [ADDR_W-1:0] dst_m;
    logic [DATA_W-1:0] val_m;
    logic              claim_en;
    logic [ADDR_W-1:0] claim_dst_e;
    logic [ADDR_W-1:0] claim_dst_m;
    logic              stall;
    logic              sb_err;
    logic [ADDR_W-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output src_a, src_b, wb_valid, dst_e, val_e, dst_m, val_m,
               claim_en, claim_dst_e, claim_dst_m, dbg_sel,
        input  val_a, val_b, stall, sb_err, dbg_data
    );

    modport slave (
        input  src_a, src_b, wb_valid, dst_e, val_e, dst_m, val_m,
               claim_en, claim_dst_e, claim_dst_m, dbg_sel,
        output val_a, val_b, stall, sb_err, dbg_data
    );

endinterface

// File: rtl/y86_scoreboard.sv
// Per-register pending-write counters, sticky error flag and decode stall.
// Optional macro WB_BYPASS_EN suppresses stall when the last pending write retires this cycle.
module y86_scoreboard
    import y86_pkg::*;
#(
    parameter int unsigned NUM_REGS = 15,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned PEND_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              claim_en_i,
    input  logic [ADDR_W-1:0] claim_dst_e_i,
    input  logic [ADDR_W-1:0] claim_dst_m_i,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] dst_e_i,
    input  logic [ADDR_W-1:0] dst_m_i,
    input  logic [ADDR_W-1:0] src_a_i,
    input  logic [ADDR_W-1:0] src_b_i,
    output logic              stall_o,
    output logic              sb_err_o
);

    localparam logic [PEND_W-1:0] PendMax = '1;
    localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];
    logic              err_q, err_d;
    logic [NUM_REGS-1:0] inc, dec;
    logic              stall_a, stall_b;

    // Matching against each index dedups dstE == dstM and ignores RNONE/out-of-range ids.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            inc[i] = claim_en_i && (claim_dst_e_i == ADDR_W'(i) || claim_dst_m_i == ADDR_W'(i));
            dec[i] = wb_valid_i && (dst_e_i == ADDR_W'(i) || dst_m_i == ADDR_W'(i));
        end
    end

    always_comb begin
        err_d = err_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            pend_d[i] = pend_q[i];
            if (inc[i] && !dec[i]) begin
                if (pend_q[i] == PendMax) err_d = 1'b1;
                else                      pend_d[i] = pend_q[i] + PendOne;
            end else if (dec[i] && !inc[i]) begin
                if (pend_q[i] == '0) err_d = 1'b1;
                else                 pend_d[i] = pend_q[i] - PendOne;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) pend_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) pend_q[i] <= pend_d[i];
            err_q <= err_d;
        end
    end

    always_comb begin
        stall_a = 1'b0;
        stall_b = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (src_a_i == ADDR_W'(i) && pend_q[i] != '0) begin
                stall_a = 1'b1;
`ifdef WB_BYPASS_EN
                if (dec[i] && pend_q[i] == PendOne) stall_a = 1'b0;
`endif
            end
            if (src_b_i == ADDR_W'(i) && pend_q[i] != '0) begin
                stall_b = 1'b1;
`ifdef WB_BYPASS_EN
                if (dec[i] && pend_q[i] == PendOne) stall_b = 1'b0;
`endif
            end
        end
    end

    assign stall_o  = stall_a | stall_b;
    assign sb_err_o = err_q;

endmodule

// File: rtl/y86_regfile_pipe.sv
// Pipelined Y86-64 register file: two read ports, E/M write ports, pending-write scoreboard.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data onto the read ports.
module y86_regfile_pipe
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NUM_REGS = 15,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned PEND_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    y86_regfile_pipe_if.slave   rf
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rd_a, rd_b, rd_dbg;

    // M wins over E so popq %rsp leaves the popped value.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (rf.wb_valid) begin
                if (rf.dst_m == ADDR_W'(i))      regs_d[i] = rf.val_m;
                else if (rf.dst_e == ADDR_W'(i)) regs_d[i] = rf.val_e;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        rd_a   = '0;
        rd_b   = '0;
        rd_dbg = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rf.src_a == ADDR_W'(i))   rd_a   = regs_q[i];
            if (rf.src_b == ADDR_W'(i))   rd_b   = regs_q[i];
            if (rf.dbg_sel == ADDR_W'(i)) rd_dbg = regs_q[i];
        end
`ifdef WB_BYPASS_EN
        if (rf.wb_valid && id_in_range(32'(rf.src_a), NUM_REGS)) begin
            if (rf.dst_m == rf.src_a)      rd_a = rf.val_m;
            else if (rf.dst_e == rf.src_a) rd_a = rf.val_e;
        end
        if (rf.wb_valid && id_in_range(32'(rf.src_b), NUM_REGS)) begin
            if (rf.dst_m == rf.src_b)      rd_b = rf.val_m;
            else if (rf.dst_e == rf.src_b) rd_b = rf.val_e;
        end
`endif
    end

    assign rf.val_a    = rd_a;
    assign rf.val_b    = rd_b;
    assign rf.dbg_data = rd_dbg;

    y86_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .PEND_W   (PEND_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .claim_en_i    (rf.claim_en),
        .claim_dst_e_i (rf.claim_dst_e),
        .claim_dst_m_i (rf.claim_dst_m),
        .wb_valid_i    (rf.wb_valid),
        .dst_e_i       (rf.dst_e),
        .dst_m_i       (rf.dst_m),
        .src_a_i       (rf.src_a),
        .src_b_i       (rf.src_b),
        .stall_o       (rf.stall),
        .sb_err_o      (rf.sb_err)
    );

endmodule

// File: tb/tb_y86_regfile_pipe.sv
// Table-driven bench for y86_regfile_pipe with a queue of expected read-side results.
module tb_y86_regfile_pipe;

    logic clk;
    logic rst;

    y86_regfile_pipe_if #(.DATA_W(64), .ADDR_W(4)) rif ();

    y86_regfile_pipe #(
        .DATA_W   (64),
        .NUM_REGS (15),
        .ADDR_W   (4),
        .PEND_W   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rif)
    );

`ifdef WB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif
    localparam logic [3:0] F = 4'hF;

    typedef struct {
        logic [3:0]  src_a, src_b, dbg_sel;
        logic        wb;
        logic [3:0]  dst_e;
        logic [63:0] val_e;
        logic [3:0]  dst_m;
        logic [63:0] val_m;
        logic        claim;
        logic [3:0]  cde, cdm;
        logic [63:0] exp_a, exp_b, exp_dbg;
        logic        exp_stall, exp_err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_idx = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] dbg,
        input logic wb, input logic [3:0] de, input logic [63:0] ve,
        input logic [3:0] dm, input logic [63:0] vm,
        input logic cl, input logic [3:0] cde, input logic [3:0] cdm,
        input logic [63:0] ea, input logic [63:0] eb, input logic [63:0] ed,
        input logic es, input logic ee);
        vec_t v;
        v.src_a = sa; v.src_b = sb; v.dbg_sel = dbg;
        v.wb = wb; v.dst_e = de; v.val_e = ve; v.dst_m = dm; v.val_m = vm;
        v.claim = cl; v.cde = cde; v.cdm = cdm;
        v.exp_a = ea; v.exp_b = eb; v.exp_dbg = ed; v.exp_stall = es; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rif.src_a = v.src_a;  rif.src_b = v.src_b;  rif.dbg_sel = v.dbg_sel;
        rif.wb_valid = v.wb;  rif.dst_e = v.dst_e;  rif.val_e = v.val_e;
        rif.dst_m = v.dst_m;  rif.val_m = v.val_m;
        rif.claim_en = v.claim; rif.claim_dst_e = v.cde; rif.claim_dst_m = v.cdm;
    endtask

    // Drive one cycle's inputs, compare at the negedge, then let the posedge commit.
    task automatic step(input vec_t v);
        vec_t e;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL v%0d queue: got empty, expected entry", vec_idx);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("v%0d val_a", vec_idx), rif.val_a, e.exp_a);
            check($sformatf("v%0d val_b", vec_idx), rif.val_b, e.exp_b);
            check($sformatf("v%0d dbg_data", vec_idx), rif.dbg_data, e.exp_dbg);
            check($sformatf("v%0d stall", vec_idx), 64'(rif.stall), 64'(e.exp_stall));
            check($sformatf("v%0d sb_err", vec_idx), 64'(rif.sb_err), 64'(e.exp_err));
        end
        vec_idx++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Directed table: writes, dual write, hazards, RNONE, claim+release overlap.
        vecs.push_back(mk(0, 1, 0, 0, F, 0, F, 0, 0, F, F, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3, F, F, 0, F, 0, F, 0, 1, 3, F, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3, F, F, 1, 3, 64'h1234, F, 0, 0, F, F,
                          Byp ? 64'h1234 : 64'h0, 0, 0, !Byp, 0));
        vecs.push_back(mk(3, F, 3, 0, F, 0, F, 0, 0, F, F, 64'h1234, 0, 64'h1234, 0, 0));
        vecs.push_back(mk(F, 4, F, 0, F, 0, F, 0, 1, 4, 4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(F, 4, F, 1, 4, 64'h100, 4, 64'h200, 0, F, F,
                          0, Byp ? 64'h200 : 64'h0, 0, !Byp, 0));
        vecs.push_back(mk(4, 3, 4, 0, F, 0, F, 0, 0, F, F, 64'h200, 64'h1234, 64'h200, 0, 0));
        vecs.push_back(mk(F, 2, F, 0, F, 0, F, 0, 1, 2, F, 0, 0, 0, 0, 0));
        vecs.push_back(mk(F, 2, F, 0, F, 0, F, 0, 0, F, F, 0, 0, 0, 1, 0));
        vecs.push_back(mk(F, 2, F, 1, 2, 64'hABCD, F, 0, 0, F, F,
                          0, Byp ? 64'hABCD : 64'h0, 0, !Byp, 0));
        vecs.push_back(mk(F, 2, F, 0, F, 0, F, 0, 0, F, F, 0, 64'hABCD, 0, 0, 0));
        vecs.push_back(mk(F, F, F, 1, F, 64'hDEAD, F, 64'hBEEF, 1, F, F, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 0, F, 0, F, 0, 0, F, F, 0, 0, 64'hABCD, 0, 0));
        vecs.push_back(mk(6, F, F, 0, F, 0, F, 0, 1, 6, F, 0, 0, 0, 0, 0));
        vecs.push_back(mk(6, F, F, 1, 6, 64'h66, F, 0, 1, 6, F,
                          Byp ? 64'h66 : 64'h0, 0, 0, !Byp, 0));
        vecs.push_back(mk(6, F, 6, 0, F, 0, F, 0, 0, F, F, 64'h66, 0, 64'h66, 1, 0));
        vecs.push_back(mk(6, F, F, 1, F, 0, 6, 64'h77, 0, F, F,
                          Byp ? 64'h77 : 64'h66, 0, 0, !Byp, 0));
        vecs.push_back(mk(6, F, 6, 0, F, 0, F, 0, 0, F, F, 64'h77, 0, 64'h77, 0, 0));
        vecs.push_back(mk(F, F, F, 0, F, 0, F, 0, 1, F, 14, 0, 0, 0, 0, 0));
        vecs.push_back(mk(F, F, F, 1, F, 0, 14, 64'hEE, 0, F, F, 0, 0, 0, 0, 0));
        vecs.push_back(mk(14, F, 14, 0, F, 0, F, 0, 0, F, F, 64'hEE, 0, 64'hEE, 0, 0));

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, F, 0, F, 0, 0, F, F, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // Overflow: fourth claim on r1 at count 3 sets the sticky error.
        step(mk(1, F, F, 0, F, 0, F, 0, 1, 1, F, 0, 0, 0, 0, 0));
        step(mk(1, F, F, 0, F, 0, F, 0, 1, 1, F, 0, 0, 0, 1, 0));
        step(mk(1, F, F, 0, F, 0, F, 0, 1, 1, F, 0, 0, 0, 1, 0));
        step(mk(1, F, F, 0, F, 0, F, 0, 1, 1, F, 0, 0, 0, 1, 0));
        step(mk(1, F, F, 0, F, 0, F, 0, 0, F, F, 0, 0, 0, 1, 1));
        step(mk(1, F, F, 0, F, 0, F, 0, 0, F, F, 0, 0, 0, 1, 1));

        // r5 pending twice, one write retires: r5 holds data and still stalls.
        step(mk(5, F, F, 0, F, 0, F, 0, 1, 5, 5, 0, 0, 0, 0, 1));
        step(mk(5, F, F, 0, F, 0, F, 0, 1, 5, F, 0, 0, 0, 1, 1));
        step(mk(5, F, F, 1, 5, 64'h55, F, 0, 0, F, F, Byp ? 64'h55 : 64'h0, 0, 0, 1, 1));
        drive(mk(5, 1, 5, 0, F, 0, F, 0, 0, F, F, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("pre-reset val_a r5", rif.val_a, 64'h55);
        check("pre-reset stall r5", 64'(rif.stall), 64'h1);

        // Async reset between edges must clear state with no clock.
        #2 rst = 1'b1;
        #1;
        check("async rst stall", 64'(rif.stall), 64'h0);
        check("async rst val_a r5", rif.val_a, 64'h0);
        check("async rst dbg r5", rif.dbg_data, 64'h0);
        check("async rst sb_err", 64'(rif.sb_err), 64'h0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step(mk(5, 1, 6, 0, F, 0, F, 0, 0, F, F, 0, 0, 0, 0, 0));

        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL queue drain: got %0d left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
